// File: rtl/jump_sequencer.sv
// Jump/call/return sequencer with a return-address stack; JUMP_SEQ_TAKEN_COUNT_EN adds a taken-op counter.
// Latency: 1 cycle from accept (in_valid & in_ready) to out_valid.
// Backpressure: bundle holds while out_valid & !out_ready; in_ready low then and during flush.
module jump_sequencer #(
    parameter  int REG_ADDR_WIDTH = 4,
    parameter  int PC_WIDTH       = 16,
    parameter  int STACK_DEPTH    = 8,
    localparam int NUM_REGS       = 2**REG_ADDR_WIDTH,
    localparam int INSTR_W        = 4 + 2*REG_ADDR_WIDTH,
    localparam int CNT_W          = $clog2(STACK_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                in_kind,
    input  logic [INSTR_W-1:0]        instruction,
    input  logic [PC_WIDTH-1:0]       pc,
    input  logic [NUM_REGS-1:0]       zeroflag,
    input  logic [NUM_REGS-1:0]       signflag,
    input  logic [NUM_REGS-1:0]       overflow,
    input  logic [NUM_REGS-1:0]       errorbit,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      pc_increment,
    output logic [3:0]                alu_op,
    output logic [REG_ADDR_WIDTH-1:0] alu_a_select,
    output logic [REG_ADDR_WIDTH-1:0] alu_b_select,
    output logic [REG_ADDR_WIDTH-1:0] alu_out_select,
    output logic [1:0]                alu_load_src,
    output logic [PC_WIDTH-1:0]       out_target,
    output logic [CNT_W-1:0]          stack_count,
    output logic                      stack_overflow,
    output logic                      stack_underflow,
    output logic [15:0]               taken_count
);

    localparam int PTR_W = $clog2(STACK_DEPTH);

    localparam logic [3:0] ALU_LEFT = 4'd0;
    localparam logic [3:0] ALU_IADD = 4'd1;
    localparam logic [1:0] LD_NONE  = 2'b00;
    localparam logic [1:0] LD_ALU   = 2'b01;
    localparam logic [1:0] LD_TGT   = 2'b10;

    typedef enum logic [1:0] {
        KIND_JUMP = 2'b00,
        KIND_CALL = 2'b01,
        KIND_RET  = 2'b10,
        KIND_NOP  = 2'b11
    } kind_e;

    typedef struct packed {
        logic                      pc_increment;
        logic [3:0]                alu_op;
        logic [REG_ADDR_WIDTH-1:0] a_sel;
        logic [REG_ADDR_WIDTH-1:0] b_sel;
        logic [REG_ADDR_WIDTH-1:0] o_sel;
        logic [1:0]                load_src;
        logic [PC_WIDTH-1:0]       target;
    } bundle_t;

    localparam bundle_t BUNDLE_IDLE = '{pc_increment: 1'b1, default: '0};

    logic [1:0]                mode;
    logic [1:0]                cond;
    logic [REG_ADDR_WIDTH-1:0] flag_reg;
    logic [REG_ADDR_WIDTH-1:0] target_reg;
    kind_e                     kind;
    logic                      flag;
    logic                      taken;
    logic                      accept;
    logic                      stack_full;
    logic                      stack_empty;
    logic [PTR_W-1:0]          pop_idx;
    logic [PC_WIDTH-1:0]       ret_addr;
    logic [PC_WIDTH-1:0]       stack_mem [STACK_DEPTH];

    bundle_t bundle_q;
    bundle_t bundle_nxt;
    logic    do_push;
    logic    do_pop;
    logic    set_ovf;
    logic    set_unf;

    assign {mode, cond, flag_reg, target_reg} = instruction;
    assign kind        = kind_e'(in_kind);
    assign in_ready    = !flush && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign stack_full  = (stack_count == CNT_W'(STACK_DEPTH));
    assign stack_empty = (stack_count == '0);
    assign ret_addr    = pc + PC_WIDTH'(1);
    // Low bits of a full count are zero, so the subtraction lands on the top entry.
    assign pop_idx     = stack_count[PTR_W-1:0] - PTR_W'(1);

    always_comb begin
        flag = 1'b0;
        unique case (cond)
            2'd0: flag = zeroflag[flag_reg];
            2'd1: flag = signflag[flag_reg];
            2'd2: flag = overflow[flag_reg];
            2'd3: flag = errorbit[flag_reg];
        endcase
    end

    assign taken = flag ^ mode[0];

    always_comb begin
        bundle_nxt = BUNDLE_IDLE;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        unique case (kind)
            KIND_JUMP, KIND_CALL: begin
                bundle_nxt.alu_op       = mode[1] ? ALU_IADD : ALU_LEFT;
                bundle_nxt.a_sel        = target_reg;
                bundle_nxt.pc_increment = !taken;
                bundle_nxt.load_src     = taken ? LD_ALU : LD_NONE;
                if (kind == KIND_CALL && taken) begin
                    do_push = !stack_full;
                    set_ovf = stack_full;
                end
            end
            KIND_RET: begin
                if (taken && !stack_empty) begin
                    do_pop                  = 1'b1;
                    bundle_nxt.target       = stack_mem[pop_idx];
                    bundle_nxt.load_src     = LD_TGT;
                    bundle_nxt.pc_increment = 1'b0;
                end else if (taken) begin
                    set_unf = 1'b1;
                end
            end
            KIND_NOP: begin
                bundle_nxt = BUNDLE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            bundle_q        <= BUNDLE_IDLE;
            stack_count     <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            stack_count <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            bundle_q  <= bundle_nxt;
            if (do_push) stack_count <= stack_count + CNT_W'(1);
            if (do_pop)  stack_count <= stack_count - CNT_W'(1);
            if (set_ovf) stack_overflow <= 1'b1;
            if (set_unf) stack_underflow <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Entries above stack_count are dead, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (accept && do_push) begin
            stack_mem[stack_count[PTR_W-1:0]] <= ret_addr;
        end
    end

    assign pc_increment   = bundle_q.pc_increment;
    assign alu_op         = bundle_q.alu_op;
    assign alu_a_select   = bundle_q.a_sel;
    assign alu_b_select   = bundle_q.b_sel;
    assign alu_out_select = bundle_q.o_sel;
    assign alu_load_src   = bundle_q.load_src;
    assign out_target     = bundle_q.target;

`ifdef JUMP_SEQ_TAKEN_COUNT_EN
    logic [15:0] taken_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q <= '0;
        end else if (flush) begin
            taken_cnt_q <= '0;
        end else if (accept && !bundle_nxt.pc_increment && taken_cnt_q != 16'hFFFF) begin
            taken_cnt_q <= taken_cnt_q + 16'd1;
        end
    end

    assign taken_count = taken_cnt_q;
`else
    assign taken_count = '0;
`endif

endmodule

// File: tb/tb_jump_sequencer.sv
// Scoreboarded random/directed bench for jump_sequencer against a queue-based reference model.
module tb_jump_sequencer;

    localparam int RAW   = 4;
    localparam int PCW   = 16;
    localparam int DEPTH = 8;
    localparam int NR    = 16;
    localparam int IW    = 12;
    localparam int CW    = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_kind;
    logic [IW-1:0]   instruction;
    logic [PCW-1:0]  pc;
    logic [NR-1:0]   zeroflag, signflag, overflow, errorbit;
    logic            out_valid;
    logic            out_ready;
    logic            pc_increment;
    logic [3:0]      alu_op;
    logic [RAW-1:0]  alu_a_select, alu_b_select, alu_out_select;
    logic [1:0]      alu_load_src;
    logic [PCW-1:0]  out_target;
    logic [CW-1:0]   stack_count;
    logic            stack_overflow, stack_underflow;
    logic [15:0]     taken_count;

    always #5 clk = ~clk;

    jump_sequencer #(.REG_ADDR_WIDTH(RAW), .PC_WIDTH(PCW), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .instruction(instruction), .pc(pc),
        .zeroflag(zeroflag), .signflag(signflag), .overflow(overflow), .errorbit(errorbit),
        .out_valid(out_valid), .out_ready(out_ready), .pc_increment(pc_increment),
        .alu_op(alu_op), .alu_a_select(alu_a_select), .alu_b_select(alu_b_select),
        .alu_out_select(alu_out_select), .alu_load_src(alu_load_src), .out_target(out_target),
        .stack_count(stack_count), .stack_overflow(stack_overflow),
        .stack_underflow(stack_underflow), .taken_count(taken_count)
    );

    typedef struct packed {
        logic        pc_inc;
        logic [3:0]  op;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  o;
        logic [1:0]  ld;
        logic [15:0] tgt;
    } bund_t;

    bund_t       exp_q[$];
    logic [15:0] m_stack[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic        m_ov  = 1'b0;
    int          m_taken = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(input int mode, input int cond, input int fr, input int tr);
        logic [IW-1:0] r;
        r = {2'(mode), 2'(cond), 4'(fr), 4'(tr)};
        return r;
    endfunction

    // Reference behaviour: stack is a plain queue, flag picked from an array of the four flag words.
    task automatic model_op(input logic [1:0] kind, input logic [IW-1:0] ins, input logic [15:0] p,
                            output bund_t b);
        logic [15:0] fw[4];
        logic [1:0]  mode;
        logic        taken;
        fw[0] = zeroflag; fw[1] = signflag; fw[2] = overflow; fw[3] = errorbit;
        mode  = ins[11:10];
        taken = fw[ins[9:8]][ins[7:4]] ^ mode[0];
        b = '0;
        b.pc_inc = 1'b1;
        if (kind == 2'd0 || kind == 2'd1) begin
            b.op     = mode[1] ? 4'd1 : 4'd0;
            b.a      = ins[3:0];
            b.pc_inc = !taken;
            b.ld     = taken ? 2'd1 : 2'd0;
            if (kind == 2'd1 && taken) begin
                if (m_stack.size() == DEPTH) m_ovf = 1'b1;
                else m_stack.push_back(p + 16'd1);
            end
        end else if (kind == 2'd2 && taken) begin
            if (m_stack.size() > 0) begin
                b.tgt    = m_stack.pop_back();
                b.ld     = 2'd2;
                b.pc_inc = 1'b0;
            end else begin
                m_unf = 1'b1;
            end
        end
        if (!b.pc_inc && m_taken < 65535) m_taken++;
    endtask

    // Called at posedge+1; drives one cycle and returns at the next posedge+1.
    task automatic cycle(input logic v, input logic [1:0] kind, input logic [IW-1:0] ins,
                         input logic [15:0] p, input logic rdy, input logic fl);
        logic  acc;
        bund_t b;
        int    exp_tc;
        in_valid = v; in_kind = kind; instruction = ins; pc = p; out_ready = rdy; flush = fl;
        @(negedge clk);
`ifdef JUMP_SEQ_TAKEN_COUNT_EN
        exp_tc = m_taken;
`else
        exp_tc = 0;
`endif
        chk("stack_count", 32'(stack_count), 32'(m_stack.size()));
        chk("stack_overflow", 32'(stack_overflow), 32'(m_ovf));
        chk("stack_underflow", 32'(stack_underflow), 32'(m_unf));
        chk("taken_count", 32'(taken_count), 32'(exp_tc));
        chk("in_ready", 32'(in_ready), 32'(!fl && (!m_ov || rdy)));
        acc = v && in_ready;
        b = '0;
        if (acc) model_op(kind, ins, p, b);
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
            m_stack.delete();
            m_taken = 0;
            m_ov = 1'b0;
        end else if (acc) begin
            exp_q.push_back(b);
            m_ov = 1'b1;
        end else if (rdy) begin
            m_ov = 1'b0;
        end
    endtask

    // Scoreboard monitor: compares whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_bundle: out_valid=1 with nothing expected");
                end else begin
                    bund_t got;
                    got = {pc_increment, alu_op, alu_a_select, alu_b_select, alu_out_select,
                           alu_load_src, out_target};
                    checks++;
                    if (got !== exp_q[0]) begin
                        errors++;
                        $display("FAIL bundle: got %h expected %h", got, exp_q[0]);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else if (exp_q.size() != 0) begin
                checks++; errors++;
                $display("FAIL missing_bundle: out_valid=0 with %0d expected", exp_q.size());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_kind = 2'd0; instruction = '0;
        pc = '0; out_ready = 1'b0;
        zeroflag = '0; signflag = '0; overflow = '0; errorbit = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pc_increment", 32'(pc_increment), 32'd1);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_selects", 32'({alu_a_select, alu_b_select, alu_out_select}), 32'd0);
        chk("rst_load_src", 32'(alu_load_src), 32'd0);
        chk("rst_out_target", 32'(out_target), 32'd0);
        chk("rst_stack_count", 32'(stack_count), 32'd0);
        chk("rst_sticky", 32'({stack_overflow, stack_underflow}), 32'd0);
        chk("rst_taken_count", 32'(taken_count), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        zeroflag = 16'h5555;
        cycle(1, 2'd0, mk(0, 0, 5, 6), 16'h0000, 1, 0);
        chk("jump_nt_pc_inc", 32'(pc_increment), 32'd1);
        chk("jump_nt_a_sel", 32'(alu_a_select), 32'd6);
        cycle(1, 2'd0, mk(1, 0, 5, 6), 16'h0001, 1, 0);
        chk("jumpn_load_src", 32'(alu_load_src), 32'd1);
        cycle(1, 2'd0, mk(3, 0, 5, 6), 16'h0002, 1, 0);
        chk("jumpn_iadd_op", 32'(alu_op), 32'd1);

        cycle(1, 2'd1, mk(1, 0, 5, 6), 16'h0010, 1, 0);
        cycle(1, 2'd2, mk(1, 0, 5, 0), 16'h0020, 1, 0);
        chk("ret_target", 32'(out_target), 32'h0011);
        chk("ret_load_src", 32'(alu_load_src), 32'd2);

        for (int i = 0; i < 9; i++) cycle(1, 2'd1, mk(1, 0, 5, 1), 16'(16'h0100 + i), 1, 0);
        chk("ovf_after_9_calls", 32'(stack_overflow), 32'd1);
        chk("ninth_call_load_src", 32'(alu_load_src), 32'd1);
        chk("full_stack_count", 32'(stack_count), 32'd8);
        for (int i = 0; i < 9; i++) cycle(1, 2'd2, mk(1, 0, 5, 0), 16'h0200, 1, 0);
        chk("unf_after_empty_ret", 32'(stack_underflow), 32'd1);
        chk("empty_ret_pc_inc", 32'(pc_increment), 32'd1);

        cycle(0, 2'd3, '0, '0, 1, 0);
        cycle(1, 2'd1, mk(1, 0, 5, 2), 16'h0300, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 2'd0, mk(1, 0, 5, 3), 16'h0400, 0, 0);
        cycle(1, 2'd0, mk(1, 0, 5, 3), 16'h0400, 0, 1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_stack_count", 32'(stack_count), 32'd0);
        chk("flush_keeps_sticky", 32'({stack_overflow, stack_underflow}), 32'b11);
        cycle(0, 2'd3, '0, '0, 1, 0);

        cycle(1, 2'd1, mk(1, 0, 5, 4), 16'h0500, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_stack_count", 32'(stack_count), 32'd0);
        chk("midrst_sticky", 32'({stack_overflow, stack_underflow}), 32'd0);
        exp_q.delete(); m_stack.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_taken = 0; m_ov = 1'b0;
        in_valid = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 1500; i++) begin
            zeroflag = 16'($urandom); signflag = 16'($urandom);
            overflow = 16'($urandom); errorbit = 16'($urandom);
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), IW'($urandom),
                  16'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end

        repeat (4) cycle(0, 2'd3, '0, '0, 1, 0);
        chk("drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jump_sequencer.md
Name: jump_sequencer

Overview:
- Registered, parametrised successor to the combinational jump decoder.
- Accepts jump, call, return and nop operations over a valid/ready handshake and evaluates the per-register condition flags.
- Issues a one-cycle-latency ALU/PC control bundle to the datapath.
- Holds a return-address stack for call/return; sits between instruction fetch and the ALU control-word decoder.

Parameters:
REG_ADDR_WIDTH, 4, register index width; NUM_REGS = 2**REG_ADDR_WIDTH; instruction width INSTR_W = 4 + 2*REG_ADDR_WIDTH
PC_WIDTH, 16, program counter / return address width
STACK_DEPTH, 8, return-address stack entries (power of two, >=2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline/stack clear
in_valid  input  1  operation offered
in_ready  output  1  operation accepted when in_valid&in_ready
in_kind  input  2  00 jump, 01 call, 10 return, 11 nop
instruction  input  INSTR_W  {mode[1:0], cond[1:0], flag_reg, target_reg}
pc  input  PC_WIDTH  address of the offered operation
zeroflag/signflag/overflow/errorbit  input  NUM_REGS each  per-register flags
out_valid  output  1  control bundle valid
out_ready  input  1  consumer accepts bundle
pc_increment  output  1  1 = fall through
alu_op  output  4  0 LEFT, 1 IADD
alu_a_select/alu_b_select/alu_out_select  output  REG_ADDR_WIDTH  register selects
alu_load_src  output  2  00 none, 01 PC from ALU, 10 PC from out_target
out_target  output  PC_WIDTH  popped return address
stack_count  output  clog2(STACK_DEPTH)+1  occupied entries
stack_overflow/stack_underflow  output  1  sticky error flags

Behaviour:
- Reset (async, rst_n low) values:
  - out_valid=0, pc_increment=1, all other bundle outputs 0.
  - stack_count=0, both sticky flags 0.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready).
  - Accept at edge -> bundle registered, out_valid=1 next cycle (latency 1).
  - Bundle holds stable while out_valid && !out_ready.
  - Flags and pc are sampled on the accept edge only.
- Condition:
  - flag = {zeroflag,signflag,overflow,errorbit}[cond: 0 z, 1 s, 2 o, 3 e][flag_reg].
  - taken = flag ^ mode[0]; mode[0]=1 is the inverted (JN*) form.
- Jump/call bundle:
  - alu_op = mode[1] ? IADD : LEFT.
  - a_select = target_reg, b_select = 0, out_select = 0.
  - pc_increment = !taken; load_src = taken ? 01 : 00.
- Call:
  - If taken, push (pc+1) mod 2**PC_WIDTH.
  - If the stack is full: no push, stack_overflow<=1, the jump is still issued.
- Return:
  - If taken and stack non-empty: pop, out_target = top entry, load_src = 10, pc_increment = 0, alu_op = LEFT, all selects 0.
  - If taken and stack empty: stack_underflow<=1, bundle is fall-through (pc_increment=1, load_src=00).
  - If not taken: fall-through, no pop.
- Nop: fall-through bundle, selects 0.
- Stack:
  - LIFO; stack_count saturates at STACK_DEPTH, pointer never wraps.
  - Only one push or pop per accepted op.
- flush:
  - Highest priority; next edge clears out_valid and stack_count.
  - Accepts nothing; sticky flags are kept.
  - Sticky flags clear only on reset.
- Reset asserted mid-transfer: the bundle is discarded immediately, the stack is emptied.

Optional Feature:
- JUMP_SEQ_TAKEN_COUNT_EN defined:
  - Adds a 16-bit taken_count output, reset 0, cleared by flush.
  - Increments on every accepted op whose issued bundle has pc_increment=0.
  - Saturates at 16'hFFFF.
- Undefined: taken_count is driven constant 0 and no counter logic is built.

Test Plan:
- Defaults; zeroflag=16'h5555, kind=jump, instr={00,0,5,6}, out_ready=1 -> next cycle out_valid=1, pc_increment=1, alu_op=0, a_select=6, load_src=00.
- Same with mode=01 -> pc_increment=0, load_src=01. Mode=11 -> alu_op=1, load_src=01.
- Call at pc=16'h0010 with mode=01 on a clear flag, then return with mode=01 -> stack_count goes 1 then 0; return bundle has out_target=16'h0011, load_src=10.
- 9 taken calls with STACK_DEPTH=8 -> stack_count=8, stack_overflow=1; 9th bundle still has load_src=01.
- Return on empty stack -> stack_underflow=1, pc_increment=1.
- Backpressure: out_ready=0 for 3 cycles -> in_ready=0 and bundle stable; flush mid-stall -> out_valid=0, stack_count=0 next cycle.
